// File: rtl/button_pkg.sv
// Shared constants for the push-button conditioning blocks: FSM state encoding
// and default timing for the 100 MHz board clock.
package button_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        QUAL_HI   = 2'd1,
        STABLE_HI = 2'd2,
        QUAL_LO   = 2'd3
    } state_t;

    // 200 us debounce window and 20 ms long-press threshold at 100 MHz.
    localparam int unsigned DEF_STABLE_CYCLES = 20000;
    localparam int unsigned DEF_LONG_CYCLES   = 2000000;

endpackage

// File: rtl/button_debounce_sync_2ff.sv
// sync_2ff: two-flop synchronizer with asynchronous active-low reset to 0,
// shared by all asynchronous pad inputs.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

// File: rtl/button_debounce.sv
// Push-button debouncer: synchronizes the pad level and only follows a level
// held for STABLE_CYCLES cycles. Define BUTTON_LONGPRESS_EN for button_long.
module button_debounce #(
    parameter int unsigned STABLE_CYCLES = button_pkg::DEF_STABLE_CYCLES,
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned LONG_CYCLES   = button_pkg::DEF_LONG_CYCLES,
    parameter int unsigned LONG_W        = 24
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button,
    output logic button_db,
    output logic button_busy
`ifdef BUTTON_LONGPRESS_EN
    ,
    output logic button_long
`endif
);

    import button_pkg::*;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    // Out-of-range parameters elaborate this empty scope, visible in the hierarchy.
    if (STABLE_CYCLES == 0 || 64'(STABLE_CYCLES) >= (64'd1 << CNT_W)
        || 64'(LONG_CYCLES) >= (64'd1 << LONG_W)) begin : g_illegal_param_range
    end

    logic             w_s;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_db;
    logic             w_db_nxt;
    logic             r_busy;
    logic             w_busy_nxt;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (button),
        .q     (w_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= STABLE_LO;
            r_cnt   <= '0;
            r_db    <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_db    <= w_db_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_db_nxt    = r_db;
        w_busy_nxt  = r_busy;
        unique case (r_state)
            STABLE_LO: begin
                if (w_s) begin
                    w_state_nxt = QUAL_HI;
                    w_cnt_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                end
            end
            QUAL_HI: begin
                if (!w_s) begin
                    w_state_nxt = STABLE_LO;
                    w_cnt_nxt   = '0;
                    w_busy_nxt  = 1'b0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = STABLE_HI;
                    w_cnt_nxt   = '0;
                    w_db_nxt    = 1'b1;
                    w_busy_nxt  = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            STABLE_HI: begin
                if (!w_s) begin
                    w_state_nxt = QUAL_LO;
                    w_cnt_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                end
            end
            QUAL_LO: begin
                if (w_s) begin
                    w_state_nxt = STABLE_HI;
                    w_cnt_nxt   = '0;
                    w_busy_nxt  = 1'b0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = STABLE_LO;
                    w_cnt_nxt   = '0;
                    w_db_nxt    = 1'b0;
                    w_busy_nxt  = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
        endcase
    end

    assign button_db   = r_db;
    assign button_busy = r_busy;

`ifdef BUTTON_LONGPRESS_EN
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);
    localparam logic [LONG_W-1:0] LONG_SAT  = LONG_W'(LONG_CYCLES);

    logic [LONG_W-1:0] r_long_cnt;
    logic              r_long;

    // Counter parks one past the pulse point, so a single hold pulses once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_long_cnt <= '0;
            r_long     <= 1'b0;
        end else if (!r_db) begin
            r_long_cnt <= '0;
            r_long     <= 1'b0;
        end else begin
            if (r_long_cnt != LONG_SAT) begin
                r_long_cnt <= r_long_cnt + LONG_W'(1);
            end
            r_long <= (r_long_cnt == LONG_LAST);
        end
    end

    assign button_long = r_long;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench for button_debounce: a run-length reference model predicts
// every cycle's outputs for STABLE_CYCLES=4 and =1 instances.
module tb_button_debounce;

    localparam int unsigned N_A  = 4;
    localparam int unsigned N_B  = 1;
    localparam int unsigned LONG = 10;

    logic clk = 1'b0;
    logic rst_n;
    logic button;
    logic db_a, busy_a, db_b, busy_b;
`ifdef BUTTON_LONGPRESS_EN
    logic long_a, long_b;
`endif

    always #5 clk = ~clk;

    button_debounce #(
        .STABLE_CYCLES (N_A),
        .CNT_W         (16),
        .LONG_CYCLES   (LONG),
        .LONG_W        (24)
    ) dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .button      (button),
        .button_db   (db_a),
        .button_busy (busy_a)
`ifdef BUTTON_LONGPRESS_EN
        ,
        .button_long (long_a)
`endif
    );

    button_debounce #(
        .STABLE_CYCLES (N_B),
        .CNT_W         (16),
        .LONG_CYCLES   (LONG),
        .LONG_W        (24)
    ) dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .button      (button),
        .button_db   (db_b),
        .button_busy (busy_b)
`ifdef BUTTON_LONGPRESS_EN
        ,
        .button_long (long_b)
`endif
    );

    // Reference: the output flips once the synchronized level has disagreed
    // with it for n+1 consecutive samples; busy while such a run is in progress.
    typedef struct {
        logic        p1;
        logic        p2;
        logic        db;
        logic        busy;
        logic        lng;
        int unsigned run;
        int unsigned since;
    } mdl_t;

    typedef struct packed {
        logic db_a;
        logic busy_a;
        logic lng_a;
        logic db_b;
        logic busy_b;
        logic lng_b;
    } exp_t;

    mdl_t m_a, m_b;
    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.p1 = 1'b0; r.p2 = 1'b0; r.db = 1'b0; r.busy = 1'b0; r.lng = 1'b0;
        r.run = 0; r.since = 0;
        return r;
    endfunction

    function automatic mdl_t step(input mdl_t m, input logic b, input int unsigned n);
        mdl_t r = m;
        if (m.db) begin
            r.since = m.since + 1;
            r.lng   = (r.since == LONG);
        end else begin
            r.since = 0;
            r.lng   = 1'b0;
        end
        if (m.p2 != m.db) begin
            r.run = m.run + 1;
            if (r.run == n + 1) begin
                r.db  = ~m.db;
                r.run = 0;
            end
        end else begin
            r.run = 0;
        end
        r.busy = (r.run != 0);
        r.p2   = m.p1;
        r.p1   = b;
        return r;
    endfunction

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%b want=%b", name, $time, act, exp);
        end
    endtask

    task automatic cyc(input logic b);
        @(negedge clk);
        button = b;
        @(posedge clk);
        m_a = step(m_a, b, N_A);
        m_b = step(m_b, b, N_B);
        q.push_back('{m_a.db, m_a.busy, m_a.lng, m_b.db, m_b.busy, m_b.lng});
    endtask

    task automatic hold(input logic b, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) cyc(b);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("dut_a db/busy", {db_a, busy_a}, {e.db_a, e.busy_a});
                chk("dut_b db/busy", {db_b, busy_b}, {e.db_b, e.busy_b});
`ifdef BUTTON_LONGPRESS_EN
                chk("long a/b", {long_a, long_b}, {e.lng_a, e.lng_b});
`endif
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog t=%0t got=running want=finished", $time);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int unsigned len;
        logic        lvl;
        m_a = mdl_reset();
        m_b = mdl_reset();
        rst_n  = 1'b0;
        button = 1'b0;
        #12;
        chk("reset a", {db_a, busy_a}, 2'b00);
        chk("reset b", {db_b, busy_b}, 2'b00);
        #11 rst_n = 1'b1;

        hold(1'b0, 5);
        hold(1'b1, 12);
        hold(1'b0, 12);
        hold(1'b1, 3);
        hold(1'b0, 10);
        hold(1'b1, 12);
        hold(1'b0, 2); hold(1'b1, 2); hold(1'b0, 2); hold(1'b1, 2);
        hold(1'b0, 12);
        hold(1'b1, 40);
        hold(1'b0, 10);
        hold(1'b1, 40);
        hold(1'b0, 10);

        // Reset while dut_a sits in candidate-high with its count at 2.
        hold(1'b1, 5);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset a", {db_a, busy_a}, 2'b00);
        chk("async reset b", {db_b, busy_b}, 2'b00);
        m_a = mdl_reset();
        m_b = mdl_reset();
        #4 rst_n = 1'b1;
        hold(1'b1, 12);
        hold(1'b0, 12);

        for (int unsigned k = 0; k < 150; k++) begin
            lvl = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) len = $urandom_range(25, 40);
            else                           len = $urandom_range(1, 14);
            hold(lvl, len);
        end

        @(negedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_debounce.md
# button_debounce

Debounces a raw, asynchronous push-button level into a clean, single-clock-domain level `button_db`. It sits directly upstream of the falling-edge detector, whose `button` input it drives. Downstream edge detection therefore sees exactly one transition per physical press or release. An optional long-press pulse is compiled in by macro.

## Interface
- `STABLE_CYCLES`, default 20000: consecutive cycles the synchronized input must hold a new level before `button_db` follows. Legal range is 1 ≤ value < 2**`CNT_W`.
- `CNT_W`, default 16: width of the stability counter.
- `LONG_CYCLES`, default 2000000: cycles `button_db` must stay high before `button_long` pulses. Only meaningful with the macro enabled.
- `LONG_W`, default 24: width of the long-press counter. `LONG_CYCLES` < 2**`LONG_W`.
- `clk`  in  1  single system clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `button`  in  1  raw pad level, asynchronous, active-high (1 = pressed).
- `button_db`  out  1  debounced level; feeds the edge detector's `button` input.
- `button_busy`  out  1  high while a candidate level change is being qualified.
- `button_long`  out  1  one-cycle pulse on a long press. Present only when `BUTTON_LONGPRESS_EN` is defined.

## Operation
- Input path:
  - `button` passes through a two-flop synchronizer; its output is called `s`.
  - Only `s` is used by the FSM.
- FSM states:
  - STABLE_LO: `button_db`=0.
  - QUAL_HI: candidate 1; `button_db`=0, `button_busy`=1.
  - STABLE_HI: `button_db`=1.
  - QUAL_LO: candidate 0; `button_db`=1, `button_busy`=1.
- Transitions:
  - STABLE_LO → QUAL_HI when `s`=1. The counter is loaded with 0.
  - QUAL_HI, `s`=1, cnt < `STABLE_CYCLES`-1: cnt increments.
  - QUAL_HI, `s`=1, cnt = `STABLE_CYCLES`-1: go to STABLE_HI; `button_db` becomes 1 on the same edge.
  - QUAL_HI, `s`=0: back to STABLE_LO, counter cleared. A bounce never reaches the output.
  - STABLE_HI / QUAL_LO are the exact mirror with levels inverted.
- `button_db` and `button_busy` are registered, not decoded from `s`. `button_db` never changes other than on a STABLE_* entry.
- The counter does not run in STABLE_* states. In QUAL_* states it never exceeds `STABLE_CYCLES`-1, so no wrap-around is possible.
- `STABLE_CYCLES`=1 is a legal edge case: a QUAL_* state lasts exactly one cycle when `s` holds.
- Reset is asynchronous and takes effect immediately. It forces:
  - synchronizer flops = 0
  - state = STABLE_LO, cnt = 0
  - `button_db`=0, `button_busy`=0, `button_long`=0, long counter = 0
- Reset mid-qualification discards the candidate.
- If `button` is held high through reset release, it qualifies as a fresh press.

## Timing
- Let E0 be the first rising edge that samples a new, steady `button` level.
  - `s` changes at E1.
  - The state enters QUAL_* at E2.
  - `button_db` changes at E(`STABLE_CYCLES`+2).
- `button_busy` is high from E2 up to, but not including, E(`STABLE_CYCLES`+2).
- A reversal of `s` during qualification is seen one edge later: the state returns to STABLE_* and `button_busy` drops.
- Simultaneous events: on the qualifying edge, the state change and the `button_db` update occur together. No extra cycle.

## Configuration
- Macro: `BUTTON_LONGPRESS_EN`.
- Defined:
  - A long counter clears whenever `button_db`=0 and increments while `button_db`=1.
  - When it reaches `LONG_CYCLES`-1, `button_long` pulses high for exactly one cycle.
  - The counter then saturates, so there is only one pulse per press.
  - Release, then a new qualified press, re-arms it.
- Undefined: the `button_long` port, the long counter and the related parameters' logic are absent. All other behaviour is identical.

## Structure
- Shared package (`button_pkg` header) holds:
  - the 2-bit state encoding constants STABLE_LO=0, QUAL_HI=1, STABLE_HI=2, QUAL_LO=3
  - default `STABLE_CYCLES`/`LONG_CYCLES` constants for the 100 MHz board clock
- One sub-module: `sync_2ff`, a two-flop synchronizer with async active-low reset to 0. It is reusable for the other pad inputs.

## Test plan
- `STABLE_CYCLES`=4, `button` 0→1 held → `s`=1 at E1, `button_busy`=1 from E2, `button_db`=1 exactly at E6.
- `STABLE_CYCLES`=4, pulse `button` high for 3 cycles then low → `button_db` stays 0; `button_busy` returns to 0; state back to STABLE_LO.
- Press qualified, then release with 2-cycle bounces before a steady 0 → exactly one falling transition on `button_db`, at 6 edges after the final steady sample.
- Assert `rst_n`=0 while in QUAL_HI with cnt=2 → `button_db`, `button_busy` and cnt all 0 immediately; with `button` still 1 after release, `button_db`=1 at E6 relative to the first post-reset edge.
- `STABLE_CYCLES`=1 → `button_db` follows a steady change at E3.
- With `BUTTON_LONGPRESS_EN`, `LONG_CYCLES`=10, hold 30 cycles after qualification → exactly one `button_long` pulse, 10 edges after `button_db` rose; release and press again → a second single pulse.
